ring_timing_monitor: RTL and testbench
======================================

Name: ring_timing_monitor

Overview:
- Receive-side companion to the 8-phase one-hot ring timing generator.
- Samples the one-hot timing bus and the generator's shift enable every clock.
- Decodes the active phase to a binary index and checks each step against the expected rotate-right rule.
- Reports lock status, sticky fault flags and a saturating revolution count for control logic and debug.

Parameters:
WIDTH, 8, number of timing phases / bus width
IDX_W, 3, phase index width (log2 WIDTH)
LOCK_COUNT, 2, consecutive correct transitions required to enter LOCKED (1..15)
REV_W, 8, revolution counter width

Ports:
clk  input  1  rising-edge clock, same clock as the generator
reset  input  1  asynchronous, active-low reset
t_in  input  WIDTH  timing bus; t_in[WIDTH-1] is phase 0, t_in[0] is phase WIDTH-1
adv  input  1  generator shift enable, sampled on the same edge the generator uses it
clear  input  1  synchronous clear of FSM, flags and counter
phase  output  IDX_W  binary index of the active phase
phase_valid  output  1  phase holds a trusted decode
locked  output  1  high while state is LOCKED
err_onehot  output  1  sticky: non-one-hot sample seen while LOCKED
err_seq  output  1  sticky: illegal transition seen while LOCKED
rev_count  output  REV_W  completed revolutions while LOCKED, saturating
wrap_pulse  output  1  one-cycle pulse per completed revolution

Behaviour:
- Reset (async, reset=0) clears everything immediately: s_q=0, adv_q=0, state=IDLE, good_cnt=0, phase=0, phase_valid=0, locked=0, err_onehot=0, err_seq=0, rev_count=0, wrap_pulse=0.
- Sampling:
  - Each rising edge, s_q<=t_in and adv_q<=adv.
  - expected = adv_q ? rotate_right(s_q) : s_q, where rotate_right(x) = {x[0], x[WIDTH-1:1]}.
  - correct = onehot(t_in) && t_in==expected.
- FSM transitions, evaluated each edge; clear has priority:
  - clear=1: state=IDLE, good_cnt=0, both err flags=0, rev_count=0, wrap_pulse=0. s_q and adv_q still sample.
  - IDLE: onehot(t_in) -> SYNC with good_cnt=0. Otherwise stay; no flags set.
  - SYNC:
    - correct -> good_cnt+1; reaching LOCK_COUNT -> LOCKED.
    - One-hot but wrong -> good_cnt=0, stay in SYNC, no flags.
    - Not one-hot -> IDLE.
  - LOCKED:
    - correct -> stay.
    - Not one-hot -> FAULT, err_onehot=1.
    - One-hot but wrong -> FAULT, err_seq=1.
    - The two causes are exclusive; only one flag sets per fault.
  - FAULT: held until clear=1 -> IDLE. Flags are sticky; further samples are ignored.
- Outputs (all registered, one cycle after t_in):
  - phase <= index of the hot bit of t_in when onehot(t_in); otherwise holds.
  - phase_valid <= onehot(t_in) && next_state ∈ {SYNC, LOCKED}.
  - locked <= (next_state==LOCKED).
  - wrap_pulse <= 1 iff state==LOCKED, the transition is correct, adv_q=1, s_q phase=WIDTH-1 and t_in phase=0. On that same edge rev_count increments, saturating at all-ones.
- Stall: adv_q=0 with an unchanged bus counts as correct; phase is stable and no error is raised.
- Bus all-zero or multi-hot counts as not one-hot.

Test Plan:
1. Reset, then t_in=8'h80 with adv=0 for 3 cycles, then adv=1 rotating -> SYNC after first sample, locked=1 after 2 correct transitions, phase tracks 0,1,2,... one cycle behind t_in, phase_valid=1, all flags 0.
2. Locked, rotate through 8'h02 -> 8'h01 -> 8'h80 -> wrap_pulse=1 for exactly one cycle after the 8'h80 sample, rev_count=1. Run 300 revolutions -> rev_count=8'hFF and holds.
3. Locked at 8'h10 with adv=0 for 5 cycles -> phase=3 stable, locked=1, no flags. Then t_in=8'h08 while adv_q=0 -> err_seq=1, locked=0, phase_valid=0.
4. Locked, t_in 8'h20 -> 8'h60 -> err_onehot=1, err_seq=0, FAULT. A valid rotation afterwards keeps locked=0 until clear=1 for one cycle, which zeroes the flags and rev_count; relock follows after 1+LOCK_COUNT good cycles.
5. SYNC disturbances -> wrong one-hot step 8'h80 -> 8'h20 (adv_q=1) keeps SYNC, restarts good_cnt and sets no flag. 8'h00 returns the FSM to IDLE.
6. Assert reset low mid-LOCKED, between clock edges -> all outputs 0 immediately without a clock. With clear=1 and a bad sample on the same edge -> clear wins: IDLE, flags 0.

Source files
------------

// File: rtl/ring_timing_monitor_if.sv
// ring_timing_monitor_if: timing bus, control and status signals of the ring timing monitor
interface ring_timing_monitor_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int REV_W = 8
);
    logic [WIDTH-1:0] t_in;
    logic adv;
    logic clear;
    logic [IDX_W-1:0] phase;
    logic phase_valid;
    logic locked;
    logic err_onehot;
    logic err_seq;
    logic [REV_W-1:0] rev_count;
    logic wrap_pulse;
    modport master(output t_in, adv, clear,
                   input phase, phase_valid, locked, err_onehot, err_seq, rev_count, wrap_pulse);
    modport slave(input t_in, adv, clear,
                  output phase, phase_valid, locked, err_onehot, err_seq, rev_count, wrap_pulse);
endinterface

// File: rtl/ring_timing_monitor.sv
// ring_timing_monitor: checks a one-hot rotate-right timing ring, reports lock, faults and revolutions
module ring_timing_monitor #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3,
    parameter int LOCK_COUNT = 2,
    parameter int REV_W = 8
) (
    input logic clk,
    input logic reset,
    ring_timing_monitor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, LOCKED, FAULT} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0] t_in, s_q, expected;
    logic adv_q, onehot, correct, wrap_d, eo_d, es_d;
    logic [3:0] good_cnt, good_d;
    logic [IDX_W-1:0] idx;
    logic [REV_W-1:0] rev_d;
    assign t_in = bus.t_in;
    assign onehot = (|t_in) && !(|(t_in & (t_in - WIDTH'(1))));
    assign expected = adv_q ? {s_q[0], s_q[WIDTH-1:1]} : s_q;
    assign correct = onehot && t_in == expected;
    // t_in[WIDTH-1] is phase 0, so the index counts down from the MSB
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (t_in[i]) idx = IDX_W'(WIDTH - 1 - i);
    end
    always_comb begin
        state_d = state;
        good_d = good_cnt;
        eo_d = bus.err_onehot;
        es_d = bus.err_seq;
        wrap_d = 1'b0;
        rev_d = bus.rev_count;
        if (bus.clear) begin
            state_d = IDLE;
            good_d = '0;
            eo_d = 1'b0;
            es_d = 1'b0;
            rev_d = '0;
        end else begin
            case (state)
                IDLE: if (onehot) begin
                    state_d = SYNC;
                    good_d = '0;
                end
                SYNC: if (!onehot) state_d = IDLE;
                else if (correct) begin
                    good_d = good_cnt + 4'd1;
                    state_d = (good_d == 4'(LOCK_COUNT)) ? LOCKED : SYNC;
                end else good_d = '0;
                LOCKED: if (!onehot) begin
                    state_d = FAULT;
                    eo_d = 1'b1;
                end else if (!correct) begin
                    state_d = FAULT;
                    es_d = 1'b1;
                end else if (adv_q && s_q[0]) begin
                    // a correct advance out of the last phase lands on phase 0
                    wrap_d = 1'b1;
                    rev_d = (&bus.rev_count) ? bus.rev_count : bus.rev_count + REV_W'(1);
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
            adv_q <= 1'b0;
            state <= IDLE;
            good_cnt <= '0;
            bus.phase <= '0;
            bus.phase_valid <= 1'b0;
            bus.locked <= 1'b0;
            bus.err_onehot <= 1'b0;
            bus.err_seq <= 1'b0;
            bus.rev_count <= '0;
            bus.wrap_pulse <= 1'b0;
        end else begin
            s_q <= t_in;
            adv_q <= bus.adv;
            state <= state_d;
            good_cnt <= good_d;
            if (onehot) bus.phase <= idx;
            bus.phase_valid <= onehot && (state_d == SYNC || state_d == LOCKED);
            bus.locked <= state_d == LOCKED;
            bus.err_onehot <= eo_d;
            bus.err_seq <= es_d;
            bus.rev_count <= rev_d;
            bus.wrap_pulse <= wrap_d;
        end
    end
endmodule

// File: tb/tb_ring_timing_monitor.sv
// tb_ring_timing_monitor: directed and random checks of ring_timing_monitor against a reference model
module tb_ring_timing_monitor;
    localparam int LOCK_COUNT = 2;
    localparam int M_IDLE = 0, M_SYNC = 1, M_LOCKED = 2, M_FAULT = 3;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] cur;
    int m_state, m_good, m_phase, m_rev;
    logic [7:0] m_s;
    bit m_adv, m_pv, m_lk, m_eo, m_es, m_wrap;

    ring_timing_monitor_if #(.WIDTH(8), .IDX_W(3), .REV_W(8)) bus ();
    ring_timing_monitor #(.WIDTH(8), .IDX_W(3), .LOCK_COUNT(LOCK_COUNT), .REV_W(8)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [7:0] rot(logic [7:0] x);
        return {x[0], x[7:1]};
    endfunction

    function automatic bit is_oh(logic [7:0] x);
        return $countones(x) == 1;
    endfunction

    function automatic int idx_of(logic [7:0] x);
        for (int i = 0; i < 8; i++) if (x[7-i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_good = 0; m_phase = 0; m_rev = 0; m_s = 8'h00;
        m_adv = 0; m_pv = 0; m_lk = 0; m_eo = 0; m_es = 0; m_wrap = 0;
    endtask

    task automatic model(logic [7:0] t, bit c);
        bit oh, ok;
        int ns;
        oh = is_oh(t);
        ok = oh && t == (m_adv ? rot(m_s) : m_s);
        ns = m_state;
        m_wrap = 0;
        if (c) begin
            ns = M_IDLE; m_good = 0; m_eo = 0; m_es = 0; m_rev = 0;
        end else if (m_state == M_IDLE) begin
            if (oh) begin ns = M_SYNC; m_good = 0; end
        end else if (m_state == M_SYNC) begin
            if (!oh) ns = M_IDLE;
            else if (ok) begin
                m_good++;
                if (m_good == LOCK_COUNT) ns = M_LOCKED;
            end else m_good = 0;
        end else if (m_state == M_LOCKED) begin
            if (!oh) begin ns = M_FAULT; m_eo = 1; end
            else if (!ok) begin ns = M_FAULT; m_es = 1; end
            else if (m_adv && idx_of(m_s) == 7 && idx_of(t) == 0) begin
                m_wrap = 1;
                if (m_rev < 255) m_rev++;
            end
        end
        if (oh) m_phase = idx_of(t);
        m_pv = oh && (ns == M_SYNC || ns == M_LOCKED);
        m_lk = ns == M_LOCKED;
        m_state = ns;
        m_s = t;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".phase"}, 32'(bus.phase), 32'(m_phase));
        chk({tag, ".phase_valid"}, 32'(bus.phase_valid), 32'(m_pv));
        chk({tag, ".locked"}, 32'(bus.locked), 32'(m_lk));
        chk({tag, ".err_onehot"}, 32'(bus.err_onehot), 32'(m_eo));
        chk({tag, ".err_seq"}, 32'(bus.err_seq), 32'(m_es));
        chk({tag, ".rev_count"}, 32'(bus.rev_count), 32'(m_rev));
        chk({tag, ".wrap_pulse"}, 32'(bus.wrap_pulse), 32'(m_wrap));
    endtask

    task automatic cyc(string tag, logic [7:0] t, bit a, bit c);
        bus.t_in = t;
        bus.adv = a;
        bus.clear = c;
        @(posedge clk);
        model(t, c);
        m_adv = a;
        #1;
        check_all(tag);
        cur = a ? rot(t) : t;
    endtask

    task automatic rotate_to(string tag, logic [7:0] target);
        for (int i = 0; i < 16 && cur != target; i++) cyc(tag, cur, 1, 0);
        chk({tag, ".reached"}, 32'(cur), 32'(target));
    endtask

    initial begin
        bus.t_in = 8'h00;
        bus.adv = 1'b0;
        bus.clear = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset = 1'b1;
        // 1: stall then rotate into lock
        repeat (3) cyc("t1_stall", 8'h80, 0, 0);
        chk("t1_locked", 32'(bus.locked), 32'd1);
        cyc("t1_rot", 8'h80, 1, 0);
        repeat (4) cyc("t1_rot", cur, 1, 0);
        chk("t1_phase", 32'(bus.phase), 32'd4);
        // 2: wrap and saturation
        rotate_to("t2_to01", 8'h01);
        cyc("t2_01", cur, 1, 0);
        cyc("t2_80", cur, 1, 0);
        chk("t2_wrap", 32'(bus.wrap_pulse), 32'd1);
        chk("t2_rev1", 32'(bus.rev_count), 32'd1);
        cyc("t2_40", cur, 1, 0);
        chk("t2_wrap_off", 32'(bus.wrap_pulse), 32'd0);
        repeat (2400) cyc("t2_revs", cur, 1, 0);
        chk("t2_sat", 32'(bus.rev_count), 32'hFF);
        // 3: stall while locked, then illegal step
        rotate_to("t3_to10", 8'h10);
        repeat (5) cyc("t3_stall", 8'h10, 0, 0);
        chk("t3_phase", 32'(bus.phase), 32'd3);
        cyc("t3_bad", 8'h08, 0, 0);
        chk("t3_err_seq", 32'(bus.err_seq), 32'd1);
        chk("t3_unlocked", 32'(bus.locked), 32'd0);
        cyc("t3_clear", 8'h80, 0, 1);
        // 4: relock, then multi-hot fault, sticky until clear
        cyc("t4_relock", 8'h80, 1, 0);
        repeat (2) cyc("t4_relock", cur, 1, 0);
        chk("t4_locked", 32'(bus.locked), 32'd1);
        rotate_to("t4_to20", 8'h20);
        cyc("t4_20", 8'h20, 1, 0);
        cyc("t4_60", 8'h60, 1, 0);
        chk("t4_err_onehot", 32'(bus.err_onehot), 32'd1);
        chk("t4_err_seq", 32'(bus.err_seq), 32'd0);
        cur = 8'h10;
        repeat (4) cyc("t4_fault_hold", cur, 1, 0);
        chk("t4_still_unlocked", 32'(bus.locked), 32'd0);
        cyc("t4_clear", cur, 1, 1);
        chk("t4_flags_clr", 32'(bus.err_onehot), 32'd0);
        repeat (3) cyc("t4_relock2", cur, 1, 0);
        chk("t4_relocked", 32'(bus.locked), 32'd1);
        // 5: disturbances during SYNC
        cyc("t5_clear", cur, 1, 1);
        cyc("t5_sync", 8'h80, 1, 0);
        cyc("t5_wrong", 8'h20, 1, 0);
        chk("t5_sync_valid", 32'(bus.phase_valid), 32'd1);
        chk("t5_no_flag", 32'(bus.err_seq), 32'd0);
        cyc("t5_good", 8'h10, 1, 0);
        chk("t5_not_locked", 32'(bus.locked), 32'd0);
        cyc("t5_zero", 8'h00, 1, 0);
        chk("t5_idle", 32'(bus.phase_valid), 32'd0);
        // 6: asynchronous reset mid-cycle, then clear beats a bad sample
        cur = 8'h80;
        repeat (4) cyc("t6_lock", cur, 1, 0);
        chk("t6_locked", 32'(bus.locked), 32'd1);
        reset = 1'b0;
        #1;
        model_reset();
        check_all("t6_async");
        @(negedge clk);
        reset = 1'b1;
        cur = 8'h80;
        repeat (3) cyc("t6_relock", cur, 1, 0);
        cyc("t6_clr_bad", 8'h66, 0, 1);
        chk("t6_clr_lock", 32'(bus.locked), 32'd0);
        chk("t6_clr_flag", 32'(bus.err_onehot), 32'd0);
        // random generator traffic with glitches and clears
        cur = 8'h80;
        for (int n = 0; n < 3000; n++) begin
            int r;
            logic [7:0] t;
            bit c;
            r = $urandom_range(0, 99);
            t = (r < 3) ? 8'($urandom) : cur;
            c = r >= 97;
            cyc("rand", t, 1'($urandom_range(0, 1)), c);
            if (!is_oh(cur)) cur = 8'h80;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
